// File: rtl/main_run_sequencer.sv
// main_run_sequencer: runs NUM_RUNS back-to-back executions of a Bambu `main`
// accelerator. Each run resets the DUT, pulses its start, times it until done
// (or timeout) and pushes a result record into a show-ahead result FIFO.
// Optional build macro RUN_SEQ_RESULT_COMPARE_EN adds an expected_ret input
// and grades each completed run as pass (01) or fail (10).
module main_run_sequencer #(
  parameter int  NUM_RUNS       = 4,
  parameter int  CNT_WIDTH      = 32,
  parameter int  TIMEOUT_CYCLES = 200000000,
  parameter int  FIFO_DEPTH     = 4,
  parameter int  RET_WIDTH      = 32,
  localparam int IDX_WIDTH      = $clog2(NUM_RUNS) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 go,
  output logic                 busy,
  output logic                 campaign_done,
  output logic                 dut_reset,
  output logic                 dut_start_port,
  input  logic                 dut_done_port,
  input  logic [RET_WIDTH-1:0] dut_return_port,
`ifdef RUN_SEQ_RESULT_COMPARE_EN
  input  logic [RET_WIDTH-1:0] expected_ret,
`endif
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CNT_WIDTH-1:0] res_cycles,
  output logic [1:0]           res_status,
  output logic [IDX_WIDTH-1:0] res_run_idx,
  output logic [RET_WIDTH-1:0] res_ret
);

  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_WIDTH = CNT_WIDTH + 2 + IDX_WIDTH + RET_WIDTH;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE_C  = CNT_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] LAST_RUN_C = IDX_WIDTH'(NUM_RUNS - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE_C  = IDX_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   DEPTH_C    = (PTR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0]   FCNT_ONE_C = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE_C  = PTR_WIDTH'(1);

  localparam logic [1:0] ST_NONE_C    = 2'b00;
  localparam logic [1:0] ST_TIMEOUT_C = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                 state_r;
  logic                   rst_cnt_r;
  logic [IDX_WIDTH-1:0]   run_idx_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic                   abort_r;
  logic [CNT_WIDTH-1:0]   cap_cycles_r;
  logic [1:0]             cap_status_r;
  logic [RET_WIDTH-1:0]   cap_ret_r;
  logic                   busy_r;
  logic                   campaign_done_r;
  logic                   dut_reset_r;
  logic                   dut_start_r;

  logic [ENTRY_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_r;
  logic [PTR_WIDTH-1:0]   rd_ptr_r;
  logic [PTR_WIDTH:0]     fifo_cnt_r;
  logic [ENTRY_WIDTH-1:0] head_r;
  logic                   res_valid_r;

  logic                   fifo_full_s;
  logic                   pop_s;
  logic                   push_s;
  logic [ENTRY_WIDTH-1:0] push_data_s;
  logic [PTR_WIDTH-1:0]   rd_ptr_next_s;
  logic [PTR_WIDTH:0]     fifo_cnt_next_s;
  logic [ENTRY_WIDTH-1:0] head_next_s;
  logic [CNT_WIDTH-1:0]   cnt_inc_s;
  logic [1:0]             done_status_s;

  // Grade a completed run; without the compare feature it is always "no compare".
  always_comb begin
    done_status_s = ST_NONE_C;
`ifdef RUN_SEQ_RESULT_COMPARE_EN
    if (dut_return_port == expected_ret) begin
      done_status_s = 2'b01;
    end else begin
      done_status_s = 2'b10;
    end
`endif
  end

  // FIFO control and the next head entry, so the res_* outputs stay registered.
  always_comb begin
    fifo_full_s     = (fifo_cnt_r == DEPTH_C);
    pop_s           = (fifo_cnt_r != '0) && res_ready;
    push_s          = (state_r == S_REPORT) && (!fifo_full_s || pop_s);
    push_data_s     = {cap_cycles_r, cap_status_r, run_idx_r, cap_ret_r};
    cnt_inc_s       = cnt_r + CNT_ONE_C;
    rd_ptr_next_s   = rd_ptr_r;
    fifo_cnt_next_s = fifo_cnt_r;
    head_next_s     = '0;
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE_C;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    if (push_s && !pop_s) begin
      fifo_cnt_next_s = fifo_cnt_r + FCNT_ONE_C;
    end else if (!push_s && pop_s) begin
      fifo_cnt_next_s = fifo_cnt_r - FCNT_ONE_C;
    end else begin
      fifo_cnt_next_s = fifo_cnt_r;
    end
    // The slot being written this cycle is not yet in memory: bypass it.
    if (fifo_cnt_next_s == '0) begin
      head_next_s = '0;
    end else if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
      head_next_s = push_data_s;
    end else begin
      head_next_s = fifo_mem_r[rd_ptr_next_s];
    end
  end

  // Result FIFO storage; contents need no reset since only counted slots are read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Result FIFO pointers, occupancy and the registered head entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      fifo_cnt_r  <= '0;
      head_r      <= '0;
      res_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      rd_ptr_r    <= rd_ptr_next_s;
      fifo_cnt_r  <= fifo_cnt_next_s;
      head_r      <= head_next_s;
      res_valid_r <= (fifo_cnt_next_s != '0);
    end
  end

  // Campaign sequencer: DUT reset/start, cycle timing, reporting and abort.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= S_IDLE;
      rst_cnt_r       <= 1'b0;
      run_idx_r       <= '0;
      cnt_r           <= '0;
      abort_r         <= 1'b0;
      cap_cycles_r    <= '0;
      cap_status_r    <= ST_NONE_C;
      cap_ret_r       <= '0;
      busy_r          <= 1'b0;
      campaign_done_r <= 1'b0;
      dut_reset_r     <= 1'b1;
      dut_start_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          campaign_done_r <= 1'b0;
          dut_reset_r     <= 1'b1;
          dut_start_r     <= 1'b0;
          if (go) begin
            state_r   <= S_RST;
            run_idx_r <= '0;
            rst_cnt_r <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_RST: begin
          if (rst_cnt_r) begin
            state_r     <= S_START;
            rst_cnt_r   <= 1'b0;
            dut_reset_r <= 1'b0;
            dut_start_r <= 1'b1;
            cnt_r       <= CNT_ONE_C;
          end else begin
            rst_cnt_r   <= 1'b1;
            dut_reset_r <= 1'b1;
          end
        end
        S_START: begin
          dut_start_r <= 1'b0;
          if (dut_done_port) begin
            cap_cycles_r <= CNT_ONE_C;
            cap_status_r <= done_status_s;
            cap_ret_r    <= dut_return_port;
            dut_reset_r  <= 1'b1;
            state_r      <= S_REPORT;
          end else if (TIMEOUT_C == CNT_ONE_C) begin
            cap_cycles_r <= TIMEOUT_C;
            cap_status_r <= ST_TIMEOUT_C;
            cap_ret_r    <= '0;
            abort_r      <= 1'b1;
            dut_reset_r  <= 1'b1;
            state_r      <= S_REPORT;
          end else begin
            dut_reset_r <= 1'b0;
            state_r     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (dut_done_port) begin
            cap_cycles_r <= cnt_inc_s;
            cap_status_r <= done_status_s;
            cap_ret_r    <= dut_return_port;
            dut_reset_r  <= 1'b1;
            state_r      <= S_REPORT;
          end else if (cnt_inc_s == TIMEOUT_C) begin
            cap_cycles_r <= TIMEOUT_C;
            cap_status_r <= ST_TIMEOUT_C;
            cap_ret_r    <= '0;
            abort_r      <= 1'b1;
            dut_reset_r  <= 1'b1;
            state_r      <= S_REPORT;
          end else begin
            cnt_r       <= cnt_inc_s;
            dut_reset_r <= 1'b0;
          end
        end
        S_REPORT: begin
          // Holds the DUT in reset while waiting for a free FIFO slot.
          dut_reset_r <= 1'b1;
          if (push_s) begin
            if (abort_r || (run_idx_r == LAST_RUN_C)) begin
              state_r         <= S_DONE;
              campaign_done_r <= 1'b1;
            end else begin
              run_idx_r <= run_idx_r + IDX_ONE_C;
              rst_cnt_r <= 1'b0;
              state_r   <= S_RST;
            end
          end
        end
        S_DONE: begin
          campaign_done_r <= 1'b0;
          abort_r         <= 1'b0;
          busy_r          <= 1'b0;
          dut_reset_r     <= 1'b1;
          state_r         <= S_IDLE;
        end
        default: begin
          state_r         <= S_IDLE;
          busy_r          <= 1'b0;
          campaign_done_r <= 1'b0;
          dut_reset_r     <= 1'b1;
          dut_start_r     <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_r;
  assign campaign_done  = campaign_done_r;
  assign dut_reset      = dut_reset_r;
  assign dut_start_port = dut_start_r;
  assign res_valid      = res_valid_r;
  assign res_ret        = head_r[RET_WIDTH-1:0];
  assign res_run_idx    = head_r[RET_WIDTH +: IDX_WIDTH];
  assign res_status     = head_r[RET_WIDTH + IDX_WIDTH +: 2];
  assign res_cycles     = head_r[RET_WIDTH + IDX_WIDTH + 2 +: CNT_WIDTH];

endmodule
